// File: rtl/cntr_bs_sch_rr_if.sv
// Request-side bundle between the per-bank FIFOs/arbiter and the bank scheduler.
// The scheduler takes the slave view; the FIFO/arbiter side takes the master view.
interface cntr_bs_sch_rr_if #(
   parameter int FIFO_NUM = 7,
   parameter int BURST    = 16,
   parameter int WR_LVL_W = 6,
   parameter int IDX_W    = 3
);
   logic                             ready;
   logic [WR_LVL_W-1:0]              wr_level;
   logic [FIFO_NUM-1:0][BURST-1:0]   burst_i;
   logic [FIFO_NUM-1:0]              empty;
   logic [FIFO_NUM-1:0]              pop;
   logic                             valid_o;
   logic                             mode_o;
   logic [IDX_W-1:0]                 grant_idx;

   modport master (
      output ready, wr_level, burst_i, empty,
      input  pop, valid_o, mode_o, grant_idx
   );

   modport slave (
      input  ready, wr_level, burst_i, empty,
      output pop, valid_o, mode_o, grant_idx
   );
endinterface

// File: rtl/cntr_bs_sch_rr.sv
// Bank scheduler: picks read or write mode with watermark hysteresis, starts bursts
// round-robin per mode, then drains same-burst-address hits up to MAX_HITS pops.
module cntr_bs_sch_rr #(
   parameter int RD_FIFO_NUM = 4,
   parameter int WR_FIFO_NUM = 3,
   parameter int BURST       = 16,
   parameter int MAX_HITS    = 8,
   parameter int WR_LVL_W    = 6,
   parameter int HI_WM       = 24,
   parameter int LO_WM       = 8
) (
   input logic               clk,
   input logic               rst_n,
   cntr_bs_sch_rr_if.slave   bus
);
   localparam int FIFO_NUM = RD_FIFO_NUM + WR_FIFO_NUM;
   localparam int IDX_W    = $clog2(FIFO_NUM);
   localparam int RP_W     = (RD_FIFO_NUM > 1) ? $clog2(RD_FIFO_NUM) : 1;
   localparam int WP_W     = (WR_FIFO_NUM > 1) ? $clog2(WR_FIFO_NUM) : 1;
   localparam int HC_W     = $clog2(MAX_HITS + 1);

   localparam logic [WR_LVL_W-1:0] HI_L    = WR_LVL_W'(HI_WM);
   localparam logic [WR_LVL_W-1:0] LO_L    = WR_LVL_W'(LO_WM);
   localparam logic [HC_W-1:0]     MAX_L   = HC_W'(MAX_HITS);
   localparam logic [IDX_W:0]      RD_CNT  = (IDX_W+1)'(RD_FIFO_NUM);
   localparam logic [IDX_W:0]      WR_CNT  = (IDX_W+1)'(WR_FIFO_NUM);
   localparam logic [RP_W-1:0]     RD_LAST = RP_W'(RD_FIFO_NUM - 1);
   localparam logic [WP_W-1:0]     WR_LAST = WP_W'(WR_FIFO_NUM - 1);

   localparam logic READ  = 1'b1;
   localparam logic WRITE = 1'b0;

   typedef enum logic {S_IDLE, S_BURST} st_t;

   st_t              st, st_d;
   logic             mode_q, mode_d, mode_eff;
   logic [BURST-1:0] cb, cb_d;
   logic [RP_W-1:0]  rd_ptr, rd_ptr_d, rd_loc;
   logic [WP_W-1:0]  wr_ptr, wr_ptr_d, wr_loc;
   logic [HC_W-1:0]  hit_cnt, hit_cnt_d;
   logic             rd_found, wr_found, any_hit, any_r, any_w;
   logic [IDX_W-1:0] hit_sel, sel;
   logic             valid, fire;

   function automatic logic [HC_W-1:0] sat_inc(input logic [HC_W-1:0] x);
      return (x == {HC_W{1'b1}}) ? x : x + HC_W'(1);
   endfunction

   function automatic logic [RP_W-1:0] rd_inc(input logic [RP_W-1:0] p);
      return (p == RD_LAST) ? '0 : p + RP_W'(1);
   endfunction

   function automatic logic [WP_W-1:0] wr_inc(input logic [WP_W-1:0] p);
      return (p == WR_LAST) ? '0 : p + WP_W'(1);
   endfunction

   assign any_r = |(~bus.empty[RD_FIFO_NUM-1:0]);
   assign any_w = |(~bus.empty[FIFO_NUM-1:RD_FIFO_NUM]);

   // Mode is only re-evaluated between bursts; inside a burst it is frozen.
   always_comb begin
      mode_eff = mode_q;
      if (st == S_IDLE) begin
         if (mode_q == READ) begin
            if ((bus.wr_level >= HI_L) || (!any_r && any_w)) mode_eff = WRITE;
         end else if (((bus.wr_level <= LO_L) && any_r) || (!any_w && any_r)) begin
            mode_eff = READ;
         end
      end
   end

   // First non-empty FIFO at or after each mode's pointer, wrapping within that mode.
   always_comb begin
      logic [IDX_W:0] rj;
      logic [IDX_W:0] wj;
      rd_found = 1'b0;
      rd_loc   = '0;
      wr_found = 1'b0;
      wr_loc   = '0;
      rj       = '0;
      wj       = '0;
      for (int k = 0; k < RD_FIFO_NUM; k++) begin
         rj = (IDX_W+1)'(rd_ptr) + (IDX_W+1)'(k);
         if (rj >= RD_CNT) rj = rj - RD_CNT;
         if (!rd_found && !bus.empty[IDX_W'(rj)]) begin
            rd_found = 1'b1;
            rd_loc   = RP_W'(rj);
         end
      end
      for (int k = 0; k < WR_FIFO_NUM; k++) begin
         wj = (IDX_W+1)'(wr_ptr) + (IDX_W+1)'(k);
         if (wj >= WR_CNT) wj = wj - WR_CNT;
         if (!wr_found && !bus.empty[IDX_W'(wj + RD_CNT)]) begin
            wr_found = 1'b1;
            wr_loc   = WP_W'(wj);
         end
      end
   end

   // Lowest-index FIFO of the frozen mode whose head matches the current burst address.
   always_comb begin
      any_hit = 1'b0;
      hit_sel = '0;
      for (int i = FIFO_NUM - 1; i >= 0; i--) begin
         if (!bus.empty[i] && (bus.burst_i[i] == cb) &&
             ((i < RD_FIFO_NUM) == (mode_q == READ))) begin
            any_hit = 1'b1;
            hit_sel = IDX_W'(i);
         end
      end
   end

   always_comb begin
      st_d      = st;
      mode_d    = mode_q;
      cb_d      = cb;
      rd_ptr_d  = rd_ptr;
      wr_ptr_d  = wr_ptr;
      hit_cnt_d = hit_cnt;
      valid     = 1'b0;
      sel       = '0;
      unique case (st)
         S_IDLE: begin
            mode_d = mode_eff;
            if (mode_eff == READ) begin
               valid = rd_found;
               sel   = IDX_W'(rd_loc);
            end else begin
               valid = wr_found;
               sel   = IDX_W'(RD_FIFO_NUM) + IDX_W'(wr_loc);
            end
            if (valid && bus.ready) begin
               cb_d      = bus.burst_i[sel];
               hit_cnt_d = HC_W'(1);
               st_d      = S_BURST;
               if (mode_eff == READ) rd_ptr_d = rd_inc(rd_loc);
               else                  wr_ptr_d = wr_inc(wr_loc);
            end
         end
         S_BURST: begin
            // Leaving costs one bubble cycle with valid_o low.
            if (any_hit && (hit_cnt < MAX_L)) begin
               valid = 1'b1;
               sel   = hit_sel;
               if (bus.ready) hit_cnt_d = sat_inc(hit_cnt);
            end else begin
               st_d = S_IDLE;
            end
         end
         default: st_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st      <= S_IDLE;
         mode_q  <= READ;
         cb      <= '0;
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         hit_cnt <= '0;
      end else begin
         st      <= st_d;
         mode_q  <= mode_d;
         cb      <= cb_d;
         rd_ptr  <= rd_ptr_d;
         wr_ptr  <= wr_ptr_d;
         hit_cnt <= hit_cnt_d;
      end
   end

   // Outputs are forced quiet the moment reset asserts, without waiting for a clock.
   assign fire          = rst_n && valid && bus.ready;
   assign bus.valid_o   = rst_n && valid;
   assign bus.pop       = fire ? (FIFO_NUM'(1) << sel) : '0;
   assign bus.grant_idx = fire ? sel : '0;
   assign bus.mode_o    = mode_q;
endmodule

// File: tb/tb_cntr_bs_sch_rr.sv
// Randomised and directed bench for cntr_bs_sch_rr with a queue-based scheduler model.
module tb_cntr_bs_sch_rr;
   localparam int NR = 4, NW = 3, NF = 7, MAXH = 8, HI = 24, LO = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cntr_bs_sch_rr_if #(.FIFO_NUM(NF), .BURST(16), .WR_LVL_W(6), .IDX_W(3)) bus ();
   cntr_bs_sch_rr_if #(.FIFO_NUM(NF), .BURST(16), .WR_LVL_W(6), .IDX_W(3)) bus2 ();

   cntr_bs_sch_rr dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
   cntr_bs_sch_rr #(.MAX_HITS(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));

   int tests = 0;
   int fails = 0;

   logic [15:0] q [NF][$];

   // Model: FIFO contents live in q; scheduler state as plain variables.
   bit          m_burst, m_mode;
   logic [15:0] m_cb;
   int          m_rptr, m_wptr, m_hits;
   bit          e_fire, e_valid, e_meff;
   int          e_sel;
   logic [6:0]  exp_pop;
   logic [2:0]  exp_grant;
   bit          exp_mode;

   task automatic model_reset();
      m_burst = 0; m_mode = 1; m_cb = '0; m_rptr = 0; m_wptr = 0; m_hits = 0;
   endtask

   task automatic drive(input bit rdy);
      int wl;
      wl = 0;
      for (int i = 0; i < NF; i++) begin
         bus.empty[i]   = (q[i].size() == 0);
         bus.burst_i[i] = (q[i].size() > 0) ? q[i][0] : 16'h0;
         if (i >= NR) wl += q[i].size();
      end
      bus.wr_level = (wl > 63) ? 6'd63 : 6'(wl);
      bus.ready    = rdy;
   endtask

   task automatic settle(input bit rdy);
      int  wl, base, cnt, ptr, j;
      bit  anyr, anyw;
      drive(rdy);
      #1;
      wl = 0; anyr = 0; anyw = 0;
      for (int i = 0; i < NF; i++) begin
         if (q[i].size() > 0) begin
            if (i < NR) anyr = 1; else anyw = 1;
         end
         if (i >= NR) wl += q[i].size();
      end
      if (wl > 63) wl = 63;
      e_meff = m_mode;
      if (!m_burst) begin
         if (m_mode) begin
            if (wl >= HI || (!anyr && anyw)) e_meff = 0;
         end else if ((wl <= LO && anyr) || (!anyw && anyr)) begin
            e_meff = 1;
         end
      end
      base = e_meff ? 0 : NR;
      cnt  = e_meff ? NR : NW;
      ptr  = e_meff ? m_rptr : m_wptr;
      e_sel = -1;
      for (int k = 0; k < cnt; k++) begin
         j = m_burst ? base + k : base + (ptr + k) % cnt;
         if (e_sel < 0 && q[j].size() > 0 && (!m_burst || q[j][0] == m_cb)) e_sel = j;
      end
      e_valid   = (e_sel >= 0) && (!m_burst || m_hits < MAXH);
      e_fire    = e_valid && rdy;
      exp_pop   = e_fire ? (7'd1 << e_sel) : 7'd0;
      exp_grant = e_fire ? 3'(e_sel) : 3'd0;
      exp_mode  = m_mode;
   endtask

   task automatic advance();
      @(posedge clk);
      if (!m_burst) begin
         m_mode = e_meff;
         if (e_fire) begin
            m_cb = q[e_sel][0];
            if (e_meff) m_rptr = (e_sel + 1) % NR;
            else        m_wptr = (e_sel - NR + 1) % NW;
            m_hits  = 1;
            m_burst = 1;
         end
      end else if (e_valid) begin
         if (e_fire) m_hits++;
      end else begin
         m_burst = 0;
      end
      if (e_fire) void'(q[e_sel].pop_front());
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      for (int i = 0; i < NF; i++) q[i].delete();
      model_reset();
      drive(1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < NF; i++) q[i].delete();
      model_reset();
      q[0].push_back(16'h0001);
      q[4].push_back(16'h0002);
      drive(1'b1);
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if ({bus.valid_o, bus.pop, bus.grant_idx, bus.mode_o} !== {1'b0, 7'd0, 3'd0, 1'b1}) begin
         fails++;
         $display("FAIL reset_outputs: got v=%b pop=%b g=%0d m=%b, expected v=0 pop=0 g=0 m=1",
                  bus.valid_o, bus.pop, bus.grant_idx, bus.mode_o);
      end
      rst_n = 1'b1;
      settle(1'b1);
      tests++;
      if ({bus.valid_o, bus.pop, bus.grant_idx, bus.mode_o} !== {1'b1, 7'b0000001, 3'd0, 1'b1}) begin
         fails++;
         $display("FAIL reset_first_pop: got v=%b pop=%b g=%0d m=%b, expected v=1 pop=0000001 g=0 m=1",
                  bus.valid_o, bus.pop, bus.grant_idx, bus.mode_o);
      end
      advance();
   endtask

   task automatic test_rotation();
      logic [6:0] tpop [8] = '{7'h01, 7'h00, 7'h04, 7'h00, 7'h08, 7'h00, 7'h01, 7'h00};
      do_reset();
      q[0].push_back(16'h0011);
      q[2].push_back(16'h0022);
      for (int c = 0; c < 8; c++) begin
         if (c == 3) begin
            q[0].push_back(16'h0013);
            q[3].push_back(16'h0014);
         end
         settle(1'b1);
         tests++;
         if ({bus.valid_o, bus.pop, bus.mode_o} !== {(tpop[c] != 7'h00), tpop[c], 1'b1}) begin
            fails++;
            $display("FAIL rotation c%0d: got v=%b pop=%b m=%b, expected v=%b pop=%b m=1",
                     c, bus.valid_o, bus.pop, bus.mode_o, (tpop[c] != 7'h00), tpop[c]);
         end
         advance();
      end
   endtask

   task automatic test_same_burst();
      logic [6:0] tpop [5] = '{7'h01, 7'h02, 7'h08, 7'h00, 7'h00};
      do_reset();
      q[0].push_back(16'h00A5);
      q[1].push_back(16'h00A5);
      q[3].push_back(16'h00A5);
      for (int c = 0; c < 5; c++) begin
         settle(1'b1);
         tests++;
         if ({bus.valid_o, bus.pop} !== {(tpop[c] != 7'h00), tpop[c]}) begin
            fails++;
            $display("FAIL same_burst c%0d: got v=%b pop=%b, expected v=%b pop=%b",
                     c, bus.valid_o, bus.pop, (tpop[c] != 7'h00), tpop[c]);
         end
         advance();
      end
   endtask

   task automatic test_hit_cap();
      logic [3:0] tbl2 [13] = '{4'h1, 4'h1, 4'h0, 4'h2, 4'h1, 4'h0, 4'h4, 4'h1, 4'h0,
                                4'h8, 4'h1, 4'h0, 4'h1};
      int npops;
      do_reset();
      for (int n = 0; n < 12; n++) q[1].push_back(16'h0077);
      bus2.empty    = 7'b1110000;
      bus2.wr_level = 6'd0;
      bus2.ready    = 1'b1;
      for (int i = 0; i < NF; i++) bus2.burst_i[i] = 16'h00AA;
      npops = 0;
      for (int c = 0; c < 13; c++) begin
         settle(1'b1);
         tests++;
         if ({bus.valid_o, bus.pop, bus.grant_idx, bus.mode_o} !==
             {e_valid, exp_pop, exp_grant, exp_mode}) begin
            fails++;
            $display("FAIL hit_cap c%0d: got v=%b pop=%b g=%0d m=%b, expected v=%b pop=%b g=%0d m=%b",
                     c, bus.valid_o, bus.pop, bus.grant_idx, bus.mode_o,
                     e_valid, exp_pop, exp_grant, exp_mode);
         end
         if (c <= 8 && bus.pop != 7'd0) npops++;
         tests++;
         if (bus2.pop !== {3'b000, tbl2[c]}) begin
            fails++;
            $display("FAIL hit_cap2 c%0d: got pop=%b, expected pop=%b", c, bus2.pop, {3'b000, tbl2[c]});
         end
         advance();
      end
      tests++;
      if (npops !== 8) begin
         fails++;
         $display("FAIL hit_cap_count: got %0d pops before bubble, expected 8", npops);
      end
      bus2.empty = '1;
      bus2.ready = 1'b0;
   endtask

   task automatic test_mode_switch();
      bit saw_write, back_read;
      do_reset();
      for (int n = 0; n < 6; n++) q[0].push_back(16'h0030);
      for (int n = 0; n < 4; n++) q[1].push_back(16'h0031 + 16'(n));
      saw_write = 0; back_read = 0;
      for (int c = 0; c < 120; c++) begin
         if (c == 2) begin
            for (int n = 0; n < 24; n++) q[NR + n % NW].push_back(16'h0040 + 16'(n % 2));
         end
         settle(1'b1);
         tests++;
         if ({bus.valid_o, bus.pop, bus.grant_idx, bus.mode_o} !==
             {e_valid, exp_pop, exp_grant, exp_mode}) begin
            fails++;
            $display("FAIL mode_switch c%0d: got v=%b pop=%b g=%0d m=%b, expected v=%b pop=%b g=%0d m=%b",
                     c, bus.valid_o, bus.pop, bus.grant_idx, bus.mode_o,
                     e_valid, exp_pop, exp_grant, exp_mode);
         end
         if (c < 7 && bus.mode_o !== 1'b1) saw_write = 1;
         else if (bus.mode_o === 1'b0) saw_write = 1;
         if (saw_write && bus.mode_o === 1'b1 && c >= 7) back_read = 1;
         advance();
      end
      tests++;
      if ({saw_write, back_read} !== 2'b11) begin
         fails++;
         $display("FAIL mode_switch_seen: got write=%b back_to_read=%b, expected 1 1", saw_write, back_read);
      end
   endtask

   task automatic test_backpressure();
      int held;
      do_reset();
      for (int n = 0; n < 3; n++) q[0].push_back(16'h0050);
      held = 0;
      for (int c = 0; c < 9; c++) begin
         settle(!(c >= 1 && c <= 5));
         tests++;
         if ({bus.valid_o, bus.pop, bus.grant_idx, bus.mode_o} !==
             {e_valid, exp_pop, exp_grant, exp_mode}) begin
            fails++;
            $display("FAIL backpressure c%0d: got v=%b pop=%b g=%0d m=%b, expected v=%b pop=%b g=%0d m=%b",
                     c, bus.valid_o, bus.pop, bus.grant_idx, bus.mode_o,
                     e_valid, exp_pop, exp_grant, exp_mode);
         end
         if (c >= 1 && c <= 5 && bus.valid_o === 1'b1 && bus.pop === 7'd0) held++;
         if (c == 6) begin
            tests++;
            if (bus.pop !== 7'b0000001) begin
               fails++;
               $display("FAIL backpressure_release: got pop=%b, expected pop=0000001", bus.pop);
            end
         end
         advance();
      end
      tests++;
      if (held !== 5) begin
         fails++;
         $display("FAIL backpressure_hold: got %0d held cycles, expected 5", held);
      end
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      for (int n = 0; n < 3; n++) q[1].push_back(16'h0060);
      settle(1'b1);
      advance();
      settle(1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      tests++;
      if ({bus.valid_o, bus.pop, bus.grant_idx, bus.mode_o} !== {1'b0, 7'd0, 3'd0, 1'b1}) begin
         fails++;
         $display("FAIL reset_mid_burst: got v=%b pop=%b g=%0d m=%b, expected v=0 pop=0 g=0 m=1",
                  bus.valid_o, bus.pop, bus.grant_idx, bus.mode_o);
      end
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      q[0].push_back(16'h0070);
      for (int c = 0; c < 6; c++) begin
         settle(1'b1);
         if (c == 0) begin
            tests++;
            if ({bus.pop, bus.mode_o} !== {7'b0000001, 1'b1}) begin
               fails++;
               $display("FAIL reset_restart: got pop=%b m=%b, expected pop=0000001 m=1", bus.pop, bus.mode_o);
            end
         end
         tests++;
         if ({bus.valid_o, bus.pop, bus.grant_idx, bus.mode_o} !==
             {e_valid, exp_pop, exp_grant, exp_mode}) begin
            fails++;
            $display("FAIL reset_resume c%0d: got v=%b pop=%b g=%0d m=%b, expected v=%b pop=%b g=%0d m=%b",
                     c, bus.valid_o, bus.pop, bus.grant_idx, bus.mode_o,
                     e_valid, exp_pop, exp_grant, exp_mode);
         end
         advance();
      end
   endtask

   task automatic test_random();
      int f;
      do_reset();
      for (int c = 0; c < 800; c++) begin
         if ($urandom_range(0, 2) != 0) begin
            f = (c < 400 && $urandom_range(0, 2) != 0) ? NR + $urandom_range(0, NW - 1)
                                                       : $urandom_range(0, NF - 1);
            if (q[f].size() < 10) q[f].push_back(16'($urandom_range(0, 3)));
         end
         settle((c < 400) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) != 0));
         tests++;
         if ({bus.valid_o, bus.pop, bus.grant_idx, bus.mode_o} !==
             {e_valid, exp_pop, exp_grant, exp_mode}) begin
            fails++;
            $display("FAIL random c%0d: got v=%b pop=%b g=%0d m=%b, expected v=%b pop=%b g=%0d m=%b",
                     c, bus.valid_o, bus.pop, bus.grant_idx, bus.mode_o,
                     e_valid, exp_pop, exp_grant, exp_mode);
         end
         advance();
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus2.empty    = '1;
      bus2.ready    = 1'b0;
      bus2.wr_level = '0;
      for (int i = 0; i < NF; i++) bus2.burst_i[i] = '0;
      model_reset();
      drive(1'b0);
      test_reset();
      test_rotation();
      test_same_burst();
      test_hit_cap();
      test_mode_switch();
      test_backpressure();
      test_reset_mid_burst();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
